store_buffer: RTL and testbench

Posted-write buffer between the data cache and data memory. The cache hands every store (SB/SH/SW) to this block in one cycle. The block converts each store into a word-aligned address, byte-lane data and a byte-enable mask, queues it in a DEPTH-entry FIFO, and drains it to memory over a valid/ready handshake. It also flags loads whose word address matches a pending store, so the cache can stall instead of reading stale memory.

---
 rtl/store_buffer.sv | 130 +++++++++++++
 tb/tb_store_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write buffer: encodes SB/SH/SW stores into word address + lane data + byte enables, queues DEPTH entries, drains in order.
// Latency: a store accepted at edge N is presented to memory from edge N; no combinational st_valid -> mem_valid path.
// Backpressure: st_ready drops when full (cache holds the store); the head entry stays stable while mem_ready is low.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  input  logic [3:0]            AddrMode,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] ld_A,
  output logic                  ld_conflict,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  empty,
  output logic [31:0]           total_stores,
  output logic [31:0]           total_stall_cycles
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WAW = ADDR_WIDTH - 2;

  logic [WAW-1:0]        addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [3:0]            be_q   [DEPTH];
  logic [PW-1:0]         head, tail, rel;
  logic [PW:0]           count;

  logic                  store_code, accept, dequeue;
  logic [3:0]            enc_be;
  logic [DATA_WIDTH-1:0] enc_data;
  logic                  ld_off_unused;

  // Low address bits of a load never matter: matching is per word.
  assign ld_off_unused = ^ld_A[1:0];

  assign store_code = (AddrMode == 4'b0101) || (AddrMode == 4'b0110) || (AddrMode == 4'b0111);
  assign st_ready   = (count < (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign mem_valid  = !empty;
  assign accept     = store_code && st_valid && st_ready;
  assign dequeue    = mem_valid && mem_ready;

  assign mem_addr   = {addr_q[head], 2'b00};
  assign mem_wdata  = data_q[head];
  assign mem_be     = be_q[head];

  // Turn the incoming store into byte enables and lane-replicated data.
  always_comb begin
    enc_be   = 4'b1111;
    enc_data = WD;
    case (AddrMode)
      4'b0101: begin
        enc_be   = 4'b0001 << A[1:0];
        enc_data = {4{WD[7:0]}};
      end
      4'b0110: begin
        enc_be   = A[1] ? 4'b1100 : 4'b0011;
        enc_data = {2{WD[15:0]}};
      end
      default: begin
        enc_be   = 4'b1111;
        enc_data = WD;
      end
    endcase
  end

  // Flag a load whose word address matches any occupied entry (entries leaving this cycle still count).
  always_comb begin
    ld_conflict = 1'b0;
    rel         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - head;
      if (({1'b0, rel} < count) && (addr_q[i] == ld_A[ADDR_WIDTH-1:2]))
        ld_conflict = 1'b1;
    end
  end

  // Entry storage: written at the tail on accept, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else if (accept) begin
      addr_q[tail] <= A[ADDR_WIDTH-1:2];
      data_q[tail] <= enc_data;
      be_q[tail]   <= enc_be;
    end
  end

  // Pointers and occupancy; simultaneous accept and dequeue leaves count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept)  tail <= tail + 1'b1;
      if (dequeue) head <= head + 1'b1;
      case ({accept, dequeue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Statistics: accepted stores and cycles a real store was refused for lack of space.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_stores       <= '0;
      total_stall_cycles <= '0;
    end else begin
      if (accept) total_stores <= total_stores + 32'd1;
      if (store_code && st_valid && !st_ready) total_stall_cycles <= total_stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: queue-based reference model, directed scenarios then random traffic.
// Inputs change on the falling edge; outputs are compared 1 time unit later against the model.
// Held stores are re-offered until the model says they were taken, with a bounded retry count.
module tb_store_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [3:0]    AddrMode;
  logic [AW-1:0] A;
  logic [DW-1:0] WD;
  logic          st_ready;
  logic [AW-1:0] ld_A;
  logic          ld_conflict;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          empty;
  logic [31:0]   total_stores;
  logic [31:0]   total_stall_cycles;

  always #5 clk = ~clk;

  store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .AddrMode(AddrMode), .A(A), .WD(WD),
    .st_ready(st_ready), .ld_A(ld_A), .ld_conflict(ld_conflict), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .empty(empty), .total_stores(total_stores), .total_stall_cycles(total_stall_cycles)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_stores;
  int unsigned m_stalls;
  int          tests;
  int          fails;
  logic        took;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t encode(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] wd);
    ent_t e;
    int   off;
    off    = int'(a % 4);
    e.addr = a - a % 4;
    case (mode)
      4'b0101: begin e.be = 4'(1 << off);              e.data = wd[7:0] * 32'h0101_0101;  end
      4'b0110: begin e.be = (off >= 2) ? 4'hC : 4'h3;  e.data = wd[15:0] * 32'h0001_0001; end
      default: begin e.be = 4'hF;                      e.data = wd;                       end
    endcase
    return e;
  endfunction

  // One cycle: drive inputs, compare all outputs with the model, then advance the model past the edge.
  task automatic step(input logic sv, input logic [3:0] mode, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ld, input logic mr, output logic accepted);
    logic code, exp_ldc, deq;
    @(negedge clk);
    st_valid = sv; AddrMode = mode; A = a; WD = wd; ld_A = ld; mem_ready = mr;
    #1;
    code    = (mode == 4'd5) || (mode == 4'd6) || (mode == 4'd7);
    exp_ldc = 1'b0;
    foreach (mq[i]) if (mq[i].addr / 4 == ld / 4) exp_ldc = 1'b1;
    check("st_ready",  st_ready,  mq.size() < D);
    check("empty",     empty,     mq.size() == 0);
    check("mem_valid", mem_valid, mq.size() != 0);
    check("ld_conflict", ld_conflict, exp_ldc);
    check("total_stores", total_stores, m_stores);
    check("total_stall", total_stall_cycles, m_stalls);
    if (mq.size() != 0) begin
      check("mem_addr",  mem_addr,  mq[0].addr);
      check("mem_wdata", mem_wdata, mq[0].data);
      check("mem_be",    mem_be,    mq[0].be);
    end
    accepted = code && sv && (mq.size() < D);
    deq      = mr && (mq.size() != 0);
    if (code && sv && !(mq.size() < D)) m_stalls++;
    if (deq) void'(mq.pop_front());
    if (accepted) begin
      mq.push_back(encode(mode, a, wd));
      m_stores++;
    end
  endtask

  task automatic idle(input logic mr, input logic [31:0] ld);
    logic t;
    step(1'b0, 4'd0, 32'd0, 32'd0, ld, mr, t);
  endtask

  // Offer one store until taken, bounded so a stuck st_ready is reported rather than hanging.
  task automatic offer(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] wd, input logic mr);
    logic t;
    int   tries;
    tries = 0;
    do begin
      step(1'b1, mode, a, wd, 32'hFFFF_FFF0, mr, t);
      tries++;
    end while (!t && tries < 12);
    if (!t) check("offer_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_st_ready"},  st_ready,  1'b1);
    check({tag, "_empty"},     empty,     1'b1);
    check({tag, "_mem_valid"}, mem_valid, 1'b0);
    check({tag, "_mem_addr"},  mem_addr,  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_be"},    mem_be,    4'd0);
    check({tag, "_ld_conf"},   ld_conflict, 1'b0);
    check({tag, "_stores"},    total_stores, 32'd0);
    check({tag, "_stalls"},    total_stall_cycles, 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0; m_stores = 0; m_stalls = 0;
    reset = 1'b0; st_valid = 1'b0; AddrMode = 4'd0; A = '0; WD = '0; ld_A = '0; mem_ready = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk); reset = 1'b1;

    // SB at 0x103 held at the memory port, then drained.
    step(1'b1, 4'b0101, 32'h0000_0103, 32'h0000_00AB, 32'd0, 1'b0, took);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 32'd0);
      check("sb_addr", mem_addr, 32'h100);
      check("sb_be",   mem_be,   4'b1000);
      check("sb_data", mem_wdata, 32'hABAB_ABAB);
    end
    idle(1'b1, 32'd0);
    idle(1'b0, 32'd0);
    check("sb_drained", empty, 1'b1);
    check("sb_count",   total_stores, 32'd1);

    // SH then SW back to back, drained in order.
    offer(4'b0110, 32'h202, 32'h1234, 1'b0);
    offer(4'b0111, 32'h300, 32'hDEAD_BEEF, 1'b0);
    idle(1'b0, 32'd0);
    check("sh_addr", mem_addr, 32'h200);
    check("sh_be",   mem_be,   4'b1100);
    check("sh_data", mem_wdata, 32'h1234_1234);
    idle(1'b1, 32'd0);
    idle(1'b1, 32'd0);
    check("sw_be", mem_be, 4'b1111);
    idle(1'b1, 32'd0);

    // Fill with mem_ready low, one stalled offer, then drain across pointer wrap.
    for (int i = 0; i < 4; i++) offer(4'b0111, 32'h1000 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i), 1'b0);
    step(1'b1, 4'b0111, 32'h1010, 32'hC0DE_0004, 32'd0, 1'b0, took);
    check("full_ready", st_ready, 1'b0);
    check("full_took", took, 1'b0);
    offer(4'b0111, 32'h1010, 32'hC0DE_0004, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1, 32'd0);

    // Load conflict against a pending word.
    offer(4'b0111, 32'h400, 32'h5555_AAAA, 1'b0);
    idle(1'b0, 32'h402);
    check("ldc_hit", ld_conflict, 1'b1);
    idle(1'b0, 32'h404);
    check("ldc_miss", ld_conflict, 1'b0);
    idle(1'b1, 32'h402);
    idle(1'b0, 32'h402);
    check("ldc_drained", ld_conflict, 1'b0);

    // Reset in the middle of a drain with three entries queued.
    for (int i = 0; i < 3; i++) offer(4'b0101, 32'h2000 + 32'(i), 32'h11 * (i + 1), 1'b0);
    idle(1'b1, 32'd0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid");
    mq.delete(); m_stores = 0; m_stalls = 0;
    @(negedge clk); reset = 1'b1;
    step(1'b1, 4'b0010, 32'h3000, 32'h1, 32'd0, 1'b0, took);
    idle(1'b0, 32'd0);
    check("bad_code_stores", total_stores, 32'd0);
    check("bad_code_empty",  empty, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] mode;
      logic [31:0] a, ld;
      case ($urandom_range(0, 4))
        0:       mode = 4'b0101;
        1:       mode = 4'b0110;
        2:       mode = 4'b0111;
        3:       mode = 4'($urandom_range(0, 15));
        default: mode = 4'b0111;
      endcase
      a  = 32'h8000 + 32'($urandom_range(0, 31));
      ld = 32'h8000 + 32'($urandom_range(0, 31));
      step(1'($urandom_range(0, 3) != 0), mode, a, $urandom, ld, 1'($urandom_range(0, 2) == 0), took);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
